// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the registered 4-bit ALU: buffers requests in a FIFO,
// issues them one at a time, waits out the ALU latency and returns the captured result.
module alu_cmd_driver #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic [3:0] rsp_sel,
  output logic       rsp_err,
  output logic       busy,
  output logic [7:0] done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] waitCnt_q, waitCnt_d;
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [11:0]   fifoMem_q [DEPTH];
  logic [3:0]    aluA_q, aluB_q, aluSel_q;
  logic [7:0]    rspY_q;
  logic [3:0]    rspSel_q;
  logic          rspErr_q, rspValid_q, busy_q;
  logic [7:0]    doneCnt_q;

  logic        full, empty, push, pop, capture, rspDone, divZero;
  logic [11:0] head;

  // Pointers carry an extra wrap bit: equal means empty, MSB-only difference means full.
  assign empty     = (wrPtr_q == rdPtr_q);
  assign full      = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifoMem_q[rdPtr_q[AW-1:0]];

  // Divide or modulo by zero: the ALU result is meaningless, so it is replaced by zero.
  assign divZero = aluSel_q[3] &&
                   ((aluSel_q[2:0] == 3'b011) || (aluSel_q[2:0] == 3'b100)) &&
                   (aluB_q == 4'h0);

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    pop       = 1'b0;
    capture   = 1'b0;
    rspDone   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_d   = WAIT;
          waitCnt_d = CW'(ALU_LAT);
        end
      end
      WAIT: begin
        if (waitCnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rspValid_q && rsp_ready) begin
          rspDone = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_d   = WAIT;
            waitCnt_d = CW'(ALU_LAT);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q[AW-1:0]] <= {cmd_a, cmd_b, cmd_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      aluA_q     <= 4'h0;
      aluB_q     <= 4'h0;
      aluSel_q   <= 4'h0;
      rspY_q     <= 8'h00;
      rspSel_q   <= 4'h0;
      rspErr_q   <= 1'b0;
      rspValid_q <= 1'b0;
      busy_q     <= 1'b0;
      doneCnt_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      busy_q    <= (state_q != IDLE) || !empty;
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop) begin
        rdPtr_q  <= rdPtr_q + PW'(1);
        aluA_q   <= head[11:8];
        aluB_q   <= head[7:4];
        aluSel_q <= head[3:0];
      end
      if (capture) begin
        rspY_q     <= divZero ? 8'h00 : alu_y;
        rspSel_q   <= aluSel_q;
        rspErr_q   <= divZero;
        rspValid_q <= 1'b1;
      end else if (rspDone) begin
        rspValid_q <= 1'b0;
      end
      if (rspDone) doneCnt_q <= doneCnt_q + 8'd1;
    end
  end

  assign alu_a     = aluA_q;
  assign alu_b     = aluB_q;
  assign alu_sel   = aluSel_q;
  assign rsp_valid = rspValid_q;
  assign rsp_y     = rspY_q;
  assign rsp_sel   = rspSel_q;
  assign rsp_err   = rspErr_q;
  assign busy      = busy_q;
  assign done_cnt  = doneCnt_q;

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side initiator for the registered 4-bit ALU: accepts operation requests over a valid/ready stream and buffers them in a small FIFO. Issues each request to the ALU's operand and select inputs, waits out the ALU's registered latency, and captures the 8-bit result. Returns the result on a valid/ready response stream, with a divide/modulo-by-zero flag. Sits between a test or control sequencer and the ALU instance, sharing the ALU's clock and reset.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- ALU_LAT, 1, clock edges from ALU operand sampling to `alu_y` valid; ≥1

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  FIFO can accept
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_sel  in  4  ALU select; bit 3 = arithmetic, 0 = logic
- alu_a  out  4  registered operand A to ALU
- alu_b  out  4  registered operand B to ALU
- alu_sel  out  4  registered select to ALU
- alu_y  in  8  ALU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_y  out  8  captured result; 8'h00 when rsp_err
- rsp_sel  out  4  echo of the select that produced rsp_y
- rsp_err  out  1  divide/modulo by zero
- busy  out  1  FSM not IDLE or FIFO non-empty
- done_cnt  out  8  completed responses, wraps 8'hFF→8'h00

## Operation
- Reset: the FIFO is flushed, the FSM goes to IDLE, and every output register is cleared. `alu_a`, `alu_b`, `alu_sel`, `rsp_y`, `rsp_sel`, `rsp_err`, `rsp_valid`, `done_cnt` and `busy` are all 0. `cmd_ready` is 1 in the cycle after reset deasserts.
- Push: a request is pushed when `cmd_valid && cmd_ready`. `cmd_ready = !full`. There is no bypass: a push into an empty FIFO is not popped in the same cycle.
- Full FIFO: a pop frees a slot, but `cmd_ready` only rises in the next cycle.
- FSM state IDLE: if the FIFO is non-empty, pop the head, load `alu_a`/`alu_b`/`alu_sel`, go to WAIT, and set wait counter = ALU_LAT.
- FSM state WAIT: decrement the counter each cycle. In the cycle the counter is 0, capture `alu_y` into `rsp_y` and go to RESP.
  - WAIT therefore lasts ALU_LAT+1 cycles.
  - Operands are held stable throughout WAIT.
- FSM state RESP: `rsp_valid` = 1. Response fields hold stable until `rsp_valid && rsp_ready`.
  - On that handshake, increment `done_cnt`.
  - If the FIFO is non-empty, pop the next entry and go straight to WAIT; otherwise go to IDLE and clear `rsp_valid`.
- Error: `rsp_err` = 1 when `sel[3]=1`, `sel[2:0]` ∈ {3'b011, 3'b100}, and b = 0. In that case `rsp_y` is forced to 8'h00 and `alu_y` is ignored.
- Idle outputs: the `alu_*` outputs keep their last issued value while IDLE.
- Reset during WAIT or RESP: the in-flight command and all queued commands are discarded with no response. `done_cnt` returns to 0.
- FIFO pointers: log2(DEPTH)+1 bits. Full and empty are decoded from the MSB difference, and pointers wrap modulo 2·DEPTH.

## Timing
- Accept to response: for a command accepted at the end of cycle 0 with the FIFO empty and the FSM in IDLE, `alu_*` are valid in cycle 2 and `rsp_valid` rises in cycle ALU_LAT+3 (cycle 4 for default).
- Back-to-back throughput: one response per ALU_LAT+2 cycles while `rsp_ready` is held 1, with no IDLE cycle between commands.
- Response backpressure: `rsp_ready` = 0 stalls the FSM in RESP. The FIFO keeps accepting until full.
- `busy` is registered and reflects state/empty as of the previous edge.
- All outputs are registered; there are no combinational paths from inputs to outputs except `cmd_ready`, which is derived from the registered full flag.

## Test plan
- Arithmetic add: a=3, b=5, sel=4'b1000 → `rsp_y`=8'h08, `rsp_err`=0, `rsp_valid` in cycle 4 after accept, `done_cnt`=1.
- Width and subtract: a=4'hF, b=4'hF, sel=4'b1010 → 8'hE1; then a=3, b=5, sel=4'b1001 → 8'hFE. Back-to-back, the second `rsp_valid` arrives exactly 3 cycles after the first handshake.
- Divide by zero: a=7, b=0, sel=4'b1011 → `rsp_y`=8'h00, `rsp_err`=1, `rsp_sel`=4'b1011. Then a=7, b=2, sel=4'b1011 → 8'h03, `rsp_err`=0.
- Logic and backpressure: hold `rsp_ready`=0 and push DEPTH+1 commands (sel=4'b0010, a=4'hA, b=4'h5).
  - `cmd_ready` drops after the FIFO fills; the response is held at 8'h0F.
  - Release `rsp_ready`: all responses come out in order and `done_cnt` = DEPTH+1.
- Reset mid-operation: assert `rst` for 1 cycle during WAIT with 2 commands queued.
  - Required: `rsp_valid` never rises, all outputs read 0, `cmd_ready`=1 and `busy`=0 afterwards.
  - A new command then completes normally.
- Counter wrap: complete 256 commands → `done_cnt` = 8'h00.
